// File: rtl/ahb_bus_pkg.sv
// Shared AHB3-Lite constants and types for the bus decoder/multiplexer.
package ahb_bus_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings (AHB3-Lite single-bit response)
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave response sequencer states
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // True for transfers that demand a real response (NONSEQ or SEQ)
  function automatic logic htrans_active(input logic [1:0] htrans);
    htrans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Internal default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response and everything else with a zero-wait OKAY.
module ahb_default_slave
  import ahb_bus_pkg::*;
(
  input  logic       s_clk_i,
  input  logic       s_resetn_i,
  input  logic       unmapped,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       ds_hready,
  output logic       ds_hresp
);

  ds_state_t state_r;
  ds_state_t state_s;
  logic      req_s;
  logic      hready_n_s;
  logic      hresp_n_s;
  logic      hready_r;
  logic      hresp_r;

  // An error sequence starts only when an unmapped active transfer is accepted
  always_comb begin
    req_s = unmapped & hready & htrans_active(htrans);
  end

  // Next-state and next-response decode for the error sequencer
  always_comb begin
    state_s    = state_r;
    hready_n_s = 1'b1;
    hresp_n_s  = HRESP_OKAY;
    case (state_r)
      DS_IDLE: begin
        if (req_s) begin
          state_s = DS_ERR1;
        end else begin
          state_s = DS_IDLE;
        end
      end
      DS_ERR1: begin
        state_s = DS_ERR2;
      end
      DS_ERR2: begin
        if (req_s) begin
          state_s = DS_ERR1;
        end else begin
          state_s = DS_IDLE;
        end
      end
      default: begin
        state_s = DS_IDLE;
      end
    endcase
    case (state_s)
      DS_ERR1: begin
        hready_n_s = 1'b0;
        hresp_n_s  = HRESP_ERROR;
      end
      DS_ERR2: begin
        hready_n_s = 1'b1;
        hresp_n_s  = HRESP_ERROR;
      end
      default: begin
        hready_n_s = 1'b1;
        hresp_n_s  = HRESP_OKAY;
      end
    endcase
  end

  // State and registered response outputs, cleared asynchronously
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_r  <= DS_IDLE;
      hready_r <= 1'b1;
      hresp_r  <= HRESP_OKAY;
    end else begin
      state_r  <= state_s;
      hready_r <= hready_n_s;
      hresp_r  <= hresp_n_s;
    end
  end

  assign ds_hready = hready_r;
  assign ds_hresp  = hresp_r;

endmodule

// File: rtl/ahb_bus_mux.sv
// Single-master AHB3-Lite decoder and response multiplexer. Decodes the
// address phase into one-hot slave selects, tracks the data-phase owner and
// routes that slave's response back to the master. Unmapped space is served
// by ahb_default_slave.
module ahb_bus_mux
  import ahb_bus_pkg::*;
#(
  parameter int          SLAVES             = 4,
  parameter logic [31:0] SLV_BASE [SLAVES]  = '{32'h8000_0000, 32'h8010_0000,
                                                32'h8020_0000, 32'h0000_0000},
  parameter logic [31:0] SLV_MASK [SLAVES]  = '{32'hFFF0_0000, 32'hFFF0_0000,
                                                32'hFFF0_0000, 32'hFFF0_0000}
) (
  input  logic                     s_clk_i,
  input  logic                     s_resetn_i,
  // master request
  input  logic [31:0]              m_haddr_i,
  input  logic [31:0]              m_hwdata_i,
  input  logic [2:0]               m_hburst_i,
  input  logic                     m_hmastlock_i,
  input  logic [3:0]               m_hprot_i,
  input  logic [2:0]               m_hsize_i,
  input  logic [1:0]               m_htrans_i,
  input  logic                     m_hwrite_i,
  input  logic [5:0]               m_hparity_i,
  input  logic [6:0]               m_hwchecksum_i,
  // response to master
  output logic [31:0]              m_hrdata_o,
  output logic                     m_hready_o,
  output logic                     m_hresp_o,
  output logic [6:0]               m_hrchecksum_o,
  // slave request broadcast
  output logic [SLAVES-1:0]        s_hsel_o,
  output logic [31:0]              s_haddr_o,
  output logic [31:0]              s_hwdata_o,
  output logic [2:0]               s_hburst_o,
  output logic                     s_hmastlock_o,
  output logic [3:0]               s_hprot_o,
  output logic [2:0]               s_hsize_o,
  output logic [1:0]               s_htrans_o,
  output logic                     s_hwrite_o,
  output logic [5:0]               s_hparity_o,
  output logic [6:0]               s_hwchecksum_o,
  // per-slave responses
  input  logic [SLAVES-1:0][31:0]  s_hrdata_i,
  input  logic [SLAVES-1:0]        s_hready_i,
  input  logic [SLAVES-1:0]        s_hresp_i,
  input  logic [SLAVES-1:0][6:0]   s_hrchecksum_i
);

  logic [SLAVES-1:0] match_raw_s;
  logic [SLAVES-1:0] match_s;
  logic              found_s;
  logic              unmapped_s;
  // bit SLAVES marks the default slave as data-phase owner
  logic [SLAVES:0]   dsel_r;
  logic              ds_hready_s;
  logic              ds_hresp_s;
  logic [31:0]       hrdata_s;
  logic              hready_s;
  logic              hresp_s;
  logic [6:0]        hrchecksum_s;

  // Address decode with lowest-index priority on overlapping windows
  always_comb begin
    match_raw_s = '0;
    match_s     = '0;
    found_s     = 1'b0;
    for (int k = 0; k < SLAVES; k++) begin
      match_raw_s[k] = ((m_haddr_i & SLV_MASK[k]) == SLV_BASE[k]);
    end
    for (int k = 0; k < SLAVES; k++) begin
      match_s[k] = match_raw_s[k] & ~found_s;
      found_s    = found_s | match_raw_s[k];
    end
    unmapped_s = ~found_s;
  end

  // Slaves see no HREADY, so selects are suppressed while a data phase stalls
  always_comb begin
    if (s_resetn_i) begin
      s_hsel_o = match_s & {SLAVES{m_hready_o}};
    end else begin
      s_hsel_o = '0;
    end
  end

  // Data-phase owner advances only when the current data phase completes
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      dsel_r <= {1'b1, {SLAVES{1'b0}}};
    end else if (m_hready_o) begin
      dsel_r <= {unmapped_s, match_s};
    end else begin
      dsel_r <= dsel_r;
    end
  end

  ahb_default_slave u_default_slave (
    .s_clk_i    (s_clk_i),
    .s_resetn_i (s_resetn_i),
    .unmapped   (unmapped_s),
    .htrans     (m_htrans_i),
    .hready     (m_hready_o),
    .ds_hready  (ds_hready_s),
    .ds_hresp   (ds_hresp_s)
  );

  // AND-OR response mux; dsel_r is one-hot so exactly one source contributes.
  // The default slave returns zero data and zero checksum.
  always_comb begin
    hrdata_s     = 32'h0000_0000;
    hrchecksum_s = 7'h00;
    hready_s     = dsel_r[SLAVES] & ds_hready_s;
    hresp_s      = dsel_r[SLAVES] & ds_hresp_s;
    for (int k = 0; k < SLAVES; k++) begin
      hrdata_s     = hrdata_s     | ({32{dsel_r[k]}} & s_hrdata_i[k]);
      hrchecksum_s = hrchecksum_s | ({7{dsel_r[k]}}  & s_hrchecksum_i[k]);
      hready_s     = hready_s     | (dsel_r[k] & s_hready_i[k]);
      hresp_s      = hresp_s      | (dsel_r[k] & s_hresp_i[k]);
    end
  end

  assign m_hrdata_o     = hrdata_s;
  assign m_hready_o     = hready_s;
  assign m_hresp_o      = hresp_s;
  assign m_hrchecksum_o = hrchecksum_s;

  // Request broadcast, integrity fields passed through untouched
  assign s_haddr_o      = m_haddr_i;
  assign s_hwdata_o     = m_hwdata_i;
  assign s_hburst_o     = m_hburst_i;
  assign s_hmastlock_o  = m_hmastlock_i;
  assign s_hprot_o      = m_hprot_i;
  assign s_hsize_o      = m_hsize_i;
  assign s_htrans_o     = m_htrans_i;
  assign s_hwrite_o     = m_hwrite_i;
  assign s_hparity_o    = m_hparity_i;
  assign s_hwchecksum_o = m_hwchecksum_i;

endmodule

// File: tb/tb_ahb_bus_mux.sv
// Directed self-checking bench for ahb_bus_mux (default 4-slave map).
module tb_ahb_bus_mux;

  logic              s_clk_i;
  logic              s_resetn_i;
  logic [31:0]       m_haddr_i;
  logic [31:0]       m_hwdata_i;
  logic [2:0]        m_hburst_i;
  logic              m_hmastlock_i;
  logic [3:0]        m_hprot_i;
  logic [2:0]        m_hsize_i;
  logic [1:0]        m_htrans_i;
  logic              m_hwrite_i;
  logic [5:0]        m_hparity_i;
  logic [6:0]        m_hwchecksum_i;
  logic [31:0]       m_hrdata_o;
  logic              m_hready_o;
  logic              m_hresp_o;
  logic [6:0]        m_hrchecksum_o;
  logic [3:0]        s_hsel_o;
  logic [31:0]       s_haddr_o;
  logic [31:0]       s_hwdata_o;
  logic [2:0]        s_hburst_o;
  logic              s_hmastlock_o;
  logic [3:0]        s_hprot_o;
  logic [2:0]        s_hsize_o;
  logic [1:0]        s_htrans_o;
  logic              s_hwrite_o;
  logic [5:0]        s_hparity_o;
  logic [6:0]        s_hwchecksum_o;
  logic [3:0][31:0]  s_hrdata_i;
  logic [3:0]        s_hready_i;
  logic [3:0]        s_hresp_i;
  logic [3:0][6:0]   s_hrchecksum_i;

  int n_chk;
  int n_fail;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  ahb_bus_mux dut (
    .s_clk_i        (s_clk_i),
    .s_resetn_i     (s_resetn_i),
    .m_haddr_i      (m_haddr_i),
    .m_hwdata_i     (m_hwdata_i),
    .m_hburst_i     (m_hburst_i),
    .m_hmastlock_i  (m_hmastlock_i),
    .m_hprot_i      (m_hprot_i),
    .m_hsize_i      (m_hsize_i),
    .m_htrans_i     (m_htrans_i),
    .m_hwrite_i     (m_hwrite_i),
    .m_hparity_i    (m_hparity_i),
    .m_hwchecksum_i (m_hwchecksum_i),
    .m_hrdata_o     (m_hrdata_o),
    .m_hready_o     (m_hready_o),
    .m_hresp_o      (m_hresp_o),
    .m_hrchecksum_o (m_hrchecksum_o),
    .s_hsel_o       (s_hsel_o),
    .s_haddr_o      (s_haddr_o),
    .s_hwdata_o     (s_hwdata_o),
    .s_hburst_o     (s_hburst_o),
    .s_hmastlock_o  (s_hmastlock_o),
    .s_hprot_o      (s_hprot_o),
    .s_hsize_o      (s_hsize_o),
    .s_htrans_o     (s_htrans_o),
    .s_hwrite_o     (s_hwrite_o),
    .s_hparity_o    (s_hparity_o),
    .s_hwchecksum_o (s_hwchecksum_o),
    .s_hrdata_i     (s_hrdata_i),
    .s_hready_i     (s_hready_i),
    .s_hresp_i      (s_hresp_i),
    .s_hrchecksum_i (s_hrchecksum_i)
  );

  initial s_clk_i = 1'b0;
  always #5 s_clk_i = ~s_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a new address phase just after the falling edge
  task automatic addr_ph(input logic [31:0] a, input logic [1:0] t, input logic w);
    @(negedge s_clk_i);
    m_haddr_i  = a;
    m_htrans_i = t;
    m_hwrite_i = w;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    s_resetn_i     = 1'b0;
    m_haddr_i      = 32'h8000_0004;
    m_hwdata_i     = 32'h0;
    m_hburst_i     = 3'b000;
    m_hmastlock_i  = 1'b0;
    m_hprot_i      = 4'b0011;
    m_hsize_i      = 3'b010;
    m_htrans_i     = T_NONSEQ;
    m_hwrite_i     = 1'b0;
    m_hparity_i    = 6'h2A;
    m_hwchecksum_i = 7'h33;
    s_hrdata_i     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    s_hready_i     = 4'b1111;
    s_hresp_i      = 4'b0000;
    s_hrchecksum_i = {7'h44, 7'h33, 7'h22, 7'h11};

    // Reset state: selects gated, default-slave OKAY response
    #12;
    chk("rst_hsel",   {28'h0, s_hsel_o}, 32'h0);
    chk("rst_hready", {31'h0, m_hready_o}, 32'h1);
    chk("rst_hresp",  {31'h0, m_hresp_o}, 32'h0);
    chk("rst_hrdata", m_hrdata_o, 32'h0);
    chk("rst_hrchk",  {25'h0, m_hrchecksum_o}, 32'h0);

    // Read slave 0 at 0x8000_0004
    @(negedge s_clk_i);
    s_resetn_i = 1'b1;
    #1;
    chk("rd0_hsel",   {28'h0, s_hsel_o}, 32'h1);
    chk("rd0_haddr",  s_haddr_o, 32'h8000_0004);
    chk("pass_par",   {26'h0, s_hparity_o}, 32'h2A);
    chk("pass_wchk",  {25'h0, s_hwchecksum_o}, 32'h33);

    // Write to slave 1, data phase of slave 0 read
    addr_ph(32'h8010_0000, T_NONSEQ, 1'b1);
    s_hrdata_i[0]     = 32'hDEAD_BEEF;
    s_hrchecksum_i[0] = 7'h5A;
    #1;
    chk("wr1_hsel",   {28'h0, s_hsel_o}, 32'h2);
    chk("rd0_hrdata", m_hrdata_o, 32'hDEAD_BEEF);
    chk("rd0_hrchk",  {25'h0, m_hrchecksum_o}, 32'h5A);
    chk("rd0_hready", {31'h0, m_hready_o}, 32'h1);

    // Back-to-back read slave 2, write data phase on slave 1
    addr_ph(32'h8020_0008, T_NONSEQ, 1'b0);
    m_hwdata_i    = 32'h1234_5678;
    s_hrdata_i[1] = 32'hAAAA_0001;
    #1;
    chk("rd2_hsel",   {28'h0, s_hsel_o}, 32'h4);
    chk("wr1_hwdata", s_hwdata_o, 32'h1234_5678);
    chk("wr1_hrdata", m_hrdata_o, 32'hAAAA_0001);

    // Idle to unmapped; data phase of slave 2
    addr_ph(32'h4000_0000, T_IDLE, 1'b0);
    s_hrdata_i[2] = 32'hCAFE_0002;
    #1;
    chk("rd2_hrdata", m_hrdata_o, 32'hCAFE_0002);
    chk("idle_hsel",  {28'h0, s_hsel_o}, 32'h0);

    // Idle to unmapped answered zero-wait OKAY; then NONSEQ to unmapped
    addr_ph(32'h4000_0000, T_NONSEQ, 1'b0);
    #1;
    chk("idle_hready", {31'h0, m_hready_o}, 32'h1);
    chk("idle_hresp",  {31'h0, m_hresp_o}, 32'h0);
    chk("idle_hrdata", m_hrdata_o, 32'h0);

    // First error cycle
    addr_ph(32'h4000_0000, T_IDLE, 1'b0);
    #1;
    chk("err1_hready", {31'h0, m_hready_o}, 32'h0);
    chk("err1_hresp",  {31'h0, m_hresp_o}, 32'h1);

    // Second error cycle; a new transfer to slave 0 is accepted here
    addr_ph(32'h8000_0000, T_NONSEQ, 1'b0);
    #1;
    chk("err2_hready", {31'h0, m_hready_o}, 32'h1);
    chk("err2_hresp",  {31'h0, m_hresp_o}, 32'h1);
    chk("err2_hsel",   {28'h0, s_hsel_o}, 32'h1);

    // Transfer accepted in ERR2 completes OKAY from slave 0
    addr_ph(32'h4000_0000, T_IDLE, 1'b0);
    s_hrdata_i[0] = 32'h0BAD_F00D;
    #1;
    chk("post_hresp",  {31'h0, m_hresp_o}, 32'h0);
    chk("post_hrdata", m_hrdata_o, 32'h0BAD_F00D);

    // Stall: slave 1 holds hready low 3 cycles while slave 2 waits
    addr_ph(32'h8010_0000, T_NONSEQ, 1'b0);
    #1;
    chk("st_hsel1", {28'h0, s_hsel_o}, 32'h2);
    addr_ph(32'h8020_0000, T_NONSEQ, 1'b0);
    s_hready_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge s_clk_i);
      #1;
      chk("st_hsel_wait", {28'h0, s_hsel_o}, 32'h0);
      chk("st_hready",    {31'h0, m_hready_o}, 32'h0);
    end
    @(negedge s_clk_i);
    s_hready_i[1] = 1'b1;
    s_hrdata_i[1] = 32'h5555_AAAA;
    #1;
    chk("st_release_hsel", {28'h0, s_hsel_o}, 32'h4);
    chk("st_release_data", m_hrdata_o, 32'h5555_AAAA);

    // Slave 2 two-cycle ERROR propagates cycle-exactly
    addr_ph(32'h4000_0000, T_IDLE, 1'b0);
    s_hready_i[2] = 1'b0;
    s_hresp_i[2]  = 1'b1;
    #1;
    chk("serr1", {30'h0, m_hready_o, m_hresp_o}, 32'h1);
    @(negedge s_clk_i);
    s_hready_i[2] = 1'b1;
    #1;
    chk("serr2", {30'h0, m_hready_o, m_hresp_o}, 32'h3);

    // Back to default OKAY, then start another unmapped error
    addr_ph(32'h4000_0000, T_NONSEQ, 1'b0);
    s_hresp_i[2] = 1'b0;
    #1;
    chk("ds_okay", {30'h0, m_hready_o, m_hresp_o}, 32'h2);

    // Reset asserted in DS_ERR1
    addr_ph(32'h8000_0000, T_NONSEQ, 1'b0);
    #1;
    chk("rerr1", {30'h0, m_hready_o, m_hresp_o}, 32'h1);
    s_resetn_i = 1'b0;
    #1;
    chk("rr_resp",  {30'h0, m_hready_o, m_hresp_o}, 32'h2);
    chk("rr_hsel",  {28'h0, s_hsel_o}, 32'h0);
    chk("rr_hrdata", m_hrdata_o, 32'h0);

    // After release, data phase owner is the default slave
    addr_ph(32'h4000_0000, T_IDLE, 1'b0);
    s_resetn_i = 1'b1;
    #1;
    chk("rel_resp",   {30'h0, m_hready_o, m_hresp_o}, 32'h2);
    chk("rel_hrdata", m_hrdata_o, 32'h0);
    @(negedge s_clk_i);
    #1;
    chk("rel2_resp",  {30'h0, m_hready_o, m_hresp_o}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
